// File: rtl/antirrebote_ff.sv
// Multi-channel push-button debouncer: per-channel 2-flop synchroniser,
// enable-qualified sample history, and a registered output that moves only on a full run.

module antirrebote_lane #(
  parameter int SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  input  logic enable,
  output logic salida
);

  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic [SAMPLES-1:0] hist_q, hist_d;
  logic               sal_q, sal_d;

  always_comb begin
    s1_d   = boton;
    s2_d   = s1_q;
    hist_d = hist_q;
    sal_d  = sal_q;
    if (enable) begin
      hist_d = {hist_q[SAMPLES-2:0], s2_q};
      // The decision uses the history including this edge's sample
      if (&hist_d)       sal_d = 1'b1;
      else if (~|hist_d) sal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= '0;
      sal_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      hist_q <= hist_d;
      sal_q  <= sal_d;
    end
  end

  assign salida = sal_q;

endmodule

module antirrebote_ff #(
  parameter int WIDTH   = 16,
  parameter int SAMPLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] botones,
  input  logic             enable,
  output logic [WIDTH-1:0] salida
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    antirrebote_lane #(.SAMPLES(SAMPLES)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .boton  (botones[i]),
      .enable (enable),
      .salida (salida[i])
    );
  end

endmodule

// File: tb/tb_antirrebote_ff.sv
// Bench for antirrebote_ff: table-driven vectors, hand-written corner sequences,
// and randomized stimulus checked against a run-length reference model.

module tb_antirrebote_ff;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] botones = '0;
  logic [W-1:0] salida;

  int n_chk = 0;
  int n_fail = 0;

  antirrebote_ff #(.WIDTH(W), .SAMPLES(S)) dut (
    .clk     (clk),
    .reset   (reset),
    .botones (botones),
    .enable  (enable),
    .salida  (salida)
  );

  always #5 clk = ~clk;

  // Reference model: an output bit follows the sampled level once that level
  // has been seen on S consecutive enabled samples. Reset counts as a full run of zeros.
  logic [W-1:0] m_s1, m_s2, m_sal, run_val;
  int           run_len [W];

  function automatic int next_len(logic v, logic rv, int rl);
    int n;
    n = (v == rv) ? rl + 1 : 1;
    if (n > S) n = S;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1    <= '0;
      m_s2    <= '0;
      m_sal   <= '0;
      run_val <= '0;
      for (int i = 0; i < W; i++) run_len[i] <= S;
    end else begin
      m_s1 <= botones;
      m_s2 <= m_s1;
      if (enable) begin
        for (int i = 0; i < W; i++) begin
          run_val[i] <= m_s2[i];
          run_len[i] <= next_len(m_s2[i], run_val[i], run_len[i]);
          if (next_len(m_s2[i], run_val[i], run_len[i]) >= S) m_sal[i] <= m_s2[i];
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: salida=%h expected=%h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic         rst_n;
    logic         en;
    logic [W-1:0] bot;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic e, logic [W-1:0] b, logic [W-1:0] x);
    vec_t v;
    v.rst_n = r; v.en = e; v.bot = b; v.exp = x;
    return v;
  endfunction

  initial begin
    // Clean press of bit 0: output rises on the 6th edge after the change
    for (int k = 0; k < 6; k++) tbl.push_back(mk(1'b1, 1'b1, 16'h0001, (k == 5) ? 16'h0001 : 16'h0000));
    // Bit 0 falls and bit 15 rises on the same edge
    for (int k = 0; k < 6; k++) tbl.push_back(mk(1'b1, 1'b1, 16'h8000, (k == 5) ? 16'h8000 : 16'h0001));
    // Bounce on bit 0, two cycles per level, never a full run
    for (int k = 0; k < 20; k++) tbl.push_back(mk(1'b1, 1'b1, ((k / 2) % 2 == 0) ? 16'h8001 : 16'h8000, 16'h8000));
    for (int k = 0; k < 6; k++) tbl.push_back(mk(1'b1, 1'b1, 16'h8000, 16'h8000));
    // Release bit 15 with sampling off: output holds, then needs S enabled edges
    for (int k = 0; k < 10; k++) tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 16'h8000));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1'b1, 1'b1, 16'h0000, (k == 3) ? 16'h0000 : 16'h8000));

    // Reset state
    enable  = 1'b1;
    botones = 16'hFFFF;
    #1 check("reset_initial", salida, 16'h0000);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold_init", salida, 16'h0000);
    end
    botones = '0;
    reset   = 1'b1;

    foreach (tbl[k]) begin
      reset   = tbl[k].rst_n;
      enable  = tbl[k].en;
      botones = tbl[k].bot;
      @(negedge clk);
      check($sformatf("table[%0d]", k), salida, tbl[k].exp);
    end

    // Async reset clears a set output without a clock edge
    enable  = 1'b1;
    botones = 16'hFFFF;
    repeat (6) @(negedge clk);
    check("all_pressed", salida, 16'hFFFF);
    #2 reset = 1'b0;
    #1 check("reset_async", salida, 16'h0000);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", salida, 16'h0000);
    end
    reset = 1'b1;

    // Disabled sampling for 100 cycles, then S enabled edges
    enable  = 1'b0;
    botones = 16'h0400;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("disabled_window", salida, 16'h0000);
    end
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("enable_after_stable", salida, (k == 3) ? 16'h0400 : 16'h0000);
    end

    // Reset two samples into a press of bit 3: history is discarded
    botones = 16'h0408;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_press", salida, 16'h0400);
    end
    reset = 1'b0;
    #1 check("mid_reset_async", salida, 16'h0000);
    @(negedge clk);
    check("mid_reset_hold", salida, 16'h0000);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("after_mid_reset", salida, (k == 5) ? 16'h0408 : 16'h0000);
    end

    // Randomized: continuous and ticked enable, sparse toggles, rare resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      check("random_vs_model", salida, m_sal);
      reset   = ($urandom_range(0, 799) != 0);
      enable  = ((c % 500) < 250) ? 1'b1 : ($urandom_range(0, 3) == 0);
      botones = botones ^ W'($urandom & $urandom & $urandom & $urandom);
    end
    @(negedge clk);
    check("random_final", salida, m_sal);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
